decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, flow-controlled RV32I/RV64I instruction decode stage, parametrised on XLEN; successor to the combinational decoder.
- Sits between fetch and execute.
- Accepts {pc, insn} over a valid/ready handshake and presents decoded fields one cycle later.
- Adds optional skid buffering, full legal-opcode checking, SRAI/SRAIW alu_op fix-up, and register-usage flags for hazard logic.

Parameters:
- XLEN, 32, datapath width, 32 or 64. 64 enables OP_IMM_32 (00110) and OP_32 (01110) and widens imm/pc.
- SKID, 1, 1 = two-entry output (pipe reg + skid reg) with registered in_ready; 0 = single pipe reg with combinational in_ready.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- flush  input  1  drop all held entries
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept
- in_pc  input  XLEN  instruction address
- in_insn  input  32  instruction word
- out_valid  output  1  decoded entry valid
- out_ready  input  1  execute consumes the entry
- out_pc  output  XLEN  pc of the entry
- opcode  output  5  insn[6:2]
- alu_op  output  4  ALU function
- bcu_op  output  3  funct3
- lsu_op  output  3  funct3
- rd, rs1, rs2  output  5 each  register indices
- imm  output  XLEN  sign-extended immediate
- rd_we  output  1  writes rd, with rd != 0
- rs1_used, rs2_used  output  1 each  source operands read
- illegal  output  1  unsupported encoding

Behaviour:
- Reset (async, rst=1): out_valid=0; skid empty; every data output 0; in_ready=0 while rst is high, and 1 from the first clk edge after deassertion.
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready.
  - Latency from input transfer to out_valid is exactly 1 cycle.
  - Outputs hold stable while out_valid && !out_ready.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - The pipe reg loads on every input transfer.
  - out_valid clears on an output transfer with no input transfer in the same cycle.
- SKID=1:
  - in_ready is a flop, equal to skid-empty.
  - Input transfer while the pipe reg is full and not draining writes the decoded result into the skid reg.
  - On the next output transfer the skid reg moves to the pipe reg and in_ready returns to 1.
  - Order is preserved; no entry is dropped or duplicated.
- Decode fields (computed combinationally from in_insn before registering):
  - alu_op: OP_ALU/OP_32 give {funct7[5],funct3}.
  - OP_ALUIMM/OP_IMM_32 give {funct7[5],funct3} when funct3=101, else {0,funct3}.
  - All other opcodes give {0,funct3}.
- imm formats, each sign-extended to XLEN:
  - I: LOAD, ALUIMM, IMM_32, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - Any other opcode gives 0.
- Usage flags:
  - rs1_used: all opcodes except LUI, AUIPC, JAL.
  - rs2_used: ALU, OP_32, BRANCH, STORE.
  - rd_we: (LUI, AUIPC, JAL, JALR, LOAD, ALUIMM, ALU, IMM_32, OP_32) && rd != 0.
- illegal = 1 when any of the following holds:
  - insn[1:0] != 11;
  - the opcode is not in the supported set (LUI 01101, AUIPC 00101, JAL 11011, JALR 11001, BRANCH 11000, LOAD 00000, STORE 01000, ALUIMM 00100, ALU 01100, MISC_MEM 00011, SYSTEM 11100, plus the RV64 pair when XLEN=64);
  - BRANCH with funct3 of 010 or 011;
  - ALU with funct7 not in {0000000, 0100000}, or funct7=0100000 with funct3 not in {000, 101}.
- When illegal=1, rd_we=0 and rs1_used=rs2_used=0. The entry still flows through so execute can trap.
- flush:
  - Synchronous, with priority over everything else.
  - Clears out_valid and the skid reg at the edge.
  - An input transfer in the same cycle is discarded.
  - in_ready=1 the following cycle.
- Mid-operation reset clears everything immediately, regardless of handshake state.

Test Plan:
1. After reset, in_insn=0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle: out_valid=1, opcode=00100, rd=1, rs1=0, imm=5, alu_op=0000, rd_we=1, rs1_used=1, rs2_used=0, illegal=0.
2. in_insn=0x4030D093 (srai x1,x1,3) -> alu_op=1101, imm=0x403.
3. XLEN=64, in_insn=0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFFFFFFFFFC, rs2_used=1, rd_we=0.
4. in_insn=0x00000013 with insn[1:0] forced to 00 (0x00000010) -> illegal=1, rd_we=0. Also insn=0x0000202F (opcode 01011) -> illegal=1.
5. SKID=1, back-to-back stream of 4 instructions, out_ready held low 3 cycles:
   - In those 3 cycles, in_ready drops after the 2nd accept.
   - Once out_ready is released, all 4 emerge in order with no duplicates.
   - out_* stays stable throughout the stall.
6. flush asserted with pipe and skid both full and in_valid=1 -> next cycle out_valid=0 and in_ready=1; the next accepted instruction appears alone.

Source files
------------

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready flow control.
// The optional skid entry lets in_ready come straight from a flop.
module decode_stage #(
   parameter int XLEN = 32,
   parameter int SKID = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_insn,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      opcode,
   output logic [3:0]      alu_op,
   output logic [2:0]      bcu_op,
   output logic [2:0]      lsu_op,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [XLEN-1:0] imm,
   output logic            rd_we,
   output logic            rs1_used,
   output logic            rs2_used,
   output logic            illegal
);

   typedef enum logic [4:0] {
      OPC_LOAD     = 5'b00000,
      OPC_MISC_MEM = 5'b00011,
      OPC_ALUIMM   = 5'b00100,
      OPC_AUIPC    = 5'b00101,
      OPC_IMM_32   = 5'b00110,
      OPC_STORE    = 5'b01000,
      OPC_ALU      = 5'b01100,
      OPC_LUI      = 5'b01101,
      OPC_OP_32    = 5'b01110,
      OPC_BRANCH   = 5'b11000,
      OPC_JALR     = 5'b11001,
      OPC_JAL      = 5'b11011,
      OPC_SYSTEM   = 5'b11100
   } opc_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      opcode;
      logic [3:0]      alu_op;
      logic [2:0]      funct3;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic            rd_we;
      logic            rs1_used;
      logic            rs2_used;
      logic            illegal;
   } entry_t;

   localparam bit RV64 = (XLEN == 64);

   opc_e        opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm32;
   logic        legal_opc;
   logic        writes_rd;
   logic        reads_rs1;
   logic        reads_rs2;
   entry_t      dec;

   assign opc = opc_e'(in_insn[6:2]);
   assign f3  = in_insn[14:12];
   assign f7  = in_insn[31:25];

   always_comb begin
      imm32     = '0;
      legal_opc = 1'b0;
      writes_rd = 1'b0;
      reads_rs1 = 1'b1;
      reads_rs2 = 1'b0;
      dec        = '0;
      dec.alu_op = {1'b0, f3};
      case (opc)
         OPC_LUI, OPC_AUIPC: begin
            imm32     = {in_insn[31:12], 12'h000};
            legal_opc = 1'b1;
            writes_rd = 1'b1;
            reads_rs1 = 1'b0;
         end
         OPC_JAL: begin
            imm32     = {{12{in_insn[31]}}, in_insn[19:12], in_insn[20], in_insn[30:21], 1'b0};
            legal_opc = 1'b1;
            writes_rd = 1'b1;
            reads_rs1 = 1'b0;
         end
         OPC_JALR, OPC_LOAD: begin
            imm32     = {{20{in_insn[31]}}, in_insn[31:20]};
            legal_opc = 1'b1;
            writes_rd = 1'b1;
         end
         OPC_BRANCH: begin
            imm32     = {{20{in_insn[31]}}, in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
            legal_opc = (f3[2:1] != 2'b01);
            reads_rs2 = 1'b1;
         end
         OPC_STORE: begin
            imm32     = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
            legal_opc = 1'b1;
            reads_rs2 = 1'b1;
         end
         OPC_ALUIMM, OPC_IMM_32: begin
            // funct7[5] only selects SRAI vs SRLI; elsewhere it is immediate data
            imm32     = {{20{in_insn[31]}}, in_insn[31:20]};
            legal_opc = (opc == OPC_ALUIMM) || RV64;
            writes_rd = 1'b1;
            if (f3 == 3'b101)
               dec.alu_op = {f7[5], f3};
         end
         OPC_ALU, OPC_OP_32: begin
            if (opc == OPC_ALU)
               legal_opc = (f7 == 7'b0000000) ||
                           ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            else
               legal_opc = RV64;
            writes_rd  = 1'b1;
            reads_rs2  = 1'b1;
            dec.alu_op = {f7[5], f3};
         end
         OPC_MISC_MEM, OPC_SYSTEM: legal_opc = 1'b1;
         default: legal_opc = 1'b0;
      endcase

      dec.pc       = in_pc;
      dec.opcode   = in_insn[6:2];
      dec.funct3   = f3;
      dec.rd       = in_insn[11:7];
      dec.rs1      = in_insn[19:15];
      dec.rs2      = in_insn[24:20];
      dec.imm      = XLEN'($signed(imm32));
      dec.illegal  = (in_insn[1:0] != 2'b11) || !legal_opc;
      dec.rd_we    = writes_rd && (in_insn[11:7] != 5'd0) && !dec.illegal;
      dec.rs1_used = reads_rs1 && !dec.illegal;
      dec.rs2_used = reads_rs2 && !dec.illegal;
   end

   entry_t pipe_q, pipe_d;
   entry_t skid_q, skid_d;
   logic   pipe_v, pipe_v_d;
   logic   skid_v, skid_v_d;
   logic   rdy_q, rdy_d;
   logic   in_xfer;
   logic   out_xfer;

   // rdy_q is the whole of in_ready with a skid entry; otherwise it only masks reset
   assign in_ready = (SKID != 0) ? rdy_q : (rdy_q && (!pipe_v || out_ready));
   assign in_xfer  = in_valid && in_ready && !flush;
   assign out_xfer = pipe_v && out_ready;

   always_comb begin
      pipe_d   = pipe_q;
      skid_d   = skid_q;
      pipe_v_d = pipe_v;
      skid_v_d = skid_v;
      if (flush) begin
         pipe_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (SKID != 0) begin
         if (!pipe_v || out_xfer) begin
            if (skid_v) begin
               pipe_d   = skid_q;
               skid_v_d = 1'b0;
            end else if (in_xfer) begin
               pipe_d   = dec;
               pipe_v_d = 1'b1;
            end else begin
               pipe_v_d = 1'b0;
            end
         end else if (in_xfer) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
         end
      end else begin
         if (in_xfer) begin
            pipe_d   = dec;
            pipe_v_d = 1'b1;
         end else if (out_xfer) begin
            pipe_v_d = 1'b0;
         end
      end
      rdy_d = (SKID != 0) ? !skid_v_d : 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_q <= '0;
         skid_q <= '0;
         pipe_v <= 1'b0;
         skid_v <= 1'b0;
         rdy_q  <= 1'b0;
      end else begin
         pipe_q <= pipe_d;
         skid_q <= skid_d;
         pipe_v <= pipe_v_d;
         skid_v <= skid_v_d;
         rdy_q  <= rdy_d;
      end
   end

   assign out_valid = pipe_v;
   assign out_pc    = pipe_q.pc;
   assign opcode    = pipe_q.opcode;
   assign alu_op    = pipe_q.alu_op;
   assign bcu_op    = pipe_q.funct3;
   assign lsu_op    = pipe_q.funct3;
   assign rd        = pipe_q.rd;
   assign rs1       = pipe_q.rs1;
   assign rs2       = pipe_q.rs2;
   assign imm       = pipe_q.imm;
   assign rd_we     = pipe_q.rd_we;
   assign rs1_used  = pipe_q.rs1_used;
   assign rs2_used  = pipe_q.rs2_used;
   assign illegal   = pipe_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench: an RV64/skid and an RV32/no-skid decode_stage share one
// stimulus stream; each has its own expected-entry queue checked by a monitor.
module tb_decode_stage;

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  opcode;
      logic [3:0]  alu_op;
      logic [2:0]  bcu_op;
      logic [2:0]  lsu_op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [63:0] imm;
      logic        rd_we;
      logic        rs1_used;
      logic        rs2_used;
      logic        illegal;
   } dec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] in_pc = '0;
   logic [31:0] in_insn = '0;

   always #5 clk = ~clk;

   logic        a_in_ready, a_out_valid, a_rd_we, a_rs1_used, a_rs2_used, a_illegal;
   logic [63:0] a_out_pc, a_imm;
   logic [4:0]  a_opcode, a_rd, a_rs1, a_rs2;
   logic [3:0]  a_alu_op;
   logic [2:0]  a_bcu_op, a_lsu_op;

   logic        b_in_ready, b_out_valid, b_rd_we, b_rs1_used, b_rs2_used, b_illegal;
   logic [31:0] b_out_pc, b_imm;
   logic [4:0]  b_opcode, b_rd, b_rs1, b_rs2;
   logic [3:0]  b_alu_op;
   logic [2:0]  b_bcu_op, b_lsu_op;

   decode_stage #(.XLEN(64), .SKID(1)) dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc), .in_insn(in_insn),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
      .opcode(a_opcode), .alu_op(a_alu_op), .bcu_op(a_bcu_op), .lsu_op(a_lsu_op),
      .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .imm(a_imm),
      .rd_we(a_rd_we), .rs1_used(a_rs1_used), .rs2_used(a_rs2_used), .illegal(a_illegal)
   );

   decode_stage #(.XLEN(32), .SKID(0)) dut_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc[31:0]), .in_insn(in_insn),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
      .opcode(b_opcode), .alu_op(b_alu_op), .bcu_op(b_bcu_op), .lsu_op(b_lsu_op),
      .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .imm(b_imm),
      .rd_we(b_rd_we), .rs1_used(b_rs1_used), .rs2_used(b_rs2_used), .illegal(b_illegal)
   );

   dec_t obs_a, obs_b;
   always_comb begin
      obs_a = {a_out_pc, a_opcode, a_alu_op, a_bcu_op, a_lsu_op, a_rd, a_rs1, a_rs2,
               a_imm, a_rd_we, a_rs1_used, a_rs2_used, a_illegal};
      obs_b = {32'h0, b_out_pc, b_opcode, b_alu_op, b_bcu_op, b_lsu_op, b_rd, b_rs1, b_rs2,
               32'h0, b_imm, b_rd_we, b_rs1_used, b_rs2_used, b_illegal};
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   // Reference decoder: straight from the ISA field definitions.
   function automatic dec_t ref_decode(input logic [31:0] w, input logic [63:0] pc, input bit is64);
      dec_t        e;
      logic [4:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      longint      imm;
      bit          legal, writes, r1, r2, bad;
      op  = w[6:2];
      f3  = w[14:12];
      f7  = w[31:25];
      imm = 0;
      if (op inside {5'b00000, 5'b00100, 5'b00110, 5'b11001}) imm = longint'($signed(w[31:20]));
      else if (op == 5'b01000) imm = longint'($signed({w[31:25], w[11:7]}));
      else if (op == 5'b11000) imm = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      else if (op inside {5'b01101, 5'b00101}) imm = longint'($signed({w[31:12], 12'h000}));
      else if (op == 5'b11011) imm = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      legal = (op inside {5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000,
                          5'b01000, 5'b00100, 5'b01100, 5'b00011, 5'b11100}) ||
              (is64 && (op inside {5'b00110, 5'b01110}));
      bad = (w[1:0] != 2'b11) || !legal ||
            (op == 5'b11000 && (f3 inside {3'd2, 3'd3})) ||
            (op == 5'b01100 && !(f7 inside {7'h00, 7'h20})) ||
            (op == 5'b01100 && f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
      writes = op inside {5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b00000, 5'b00100,
                          5'b01100, 5'b00110, 5'b01110};
      r1 = !(op inside {5'b01101, 5'b00101, 5'b11011});
      r2 = op inside {5'b01100, 5'b01110, 5'b11000, 5'b01000};
      e = '0;
      if ((op inside {5'b01100, 5'b01110}) || ((op inside {5'b00100, 5'b00110}) && f3 == 3'd5))
         e.alu_op = {f7[5], f3};
      else
         e.alu_op = {1'b0, f3};
      e.pc       = is64 ? pc : {32'h0, pc[31:0]};
      e.imm      = is64 ? imm : {32'h0, imm[31:0]};
      e.opcode   = op;
      e.bcu_op   = f3;
      e.lsu_op   = f3;
      e.rd       = w[11:7];
      e.rs1      = w[19:15];
      e.rs2      = w[24:20];
      e.illegal  = bad;
      e.rd_we    = writes && (w[11:7] != 5'd0) && !bad;
      e.rs1_used = r1 && !bad;
      e.rs2_used = r2 && !bad;
      return e;
   endfunction

   dec_t q0[$];
   dec_t q1[$];
   logic mon_en = 1'b0;
   logic prev_stall [2];
   dec_t prev_o [2];

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic qclear();
      q0.delete();
      q1.delete();
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
   endtask

   task automatic mon_dut(input int d, input dec_t o, input logic ov, input logic ir);
      int   sz;
      dec_t e;
      sz = qsize(d);
      chk((d == 0) ? "a_out_valid" : "b_out_valid", 256'(ov), 256'(sz > 0));
      chk((d == 0) ? "a_in_ready" : "b_in_ready", 256'(ir),
          256'((d == 0) ? (sz < 2) : (sz == 0 || out_ready)));
      if (prev_stall[d])
         chk((d == 0) ? "a_hold" : "b_hold", 256'(o), 256'(prev_o[d]));
      if (flush) begin
         if (d == 0) q0.delete(); else q1.delete();
         prev_stall[d] = 1'b0;
      end else begin
         if (ov && out_ready && sz > 0) begin
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk((d == 0) ? "a_entry" : "b_entry", 256'(o), 256'(e));
         end
         if (in_valid && ir) begin
            if (d == 0) q0.push_back(ref_decode(in_insn, in_pc, 1'b1));
            else        q1.push_back(ref_decode(in_insn, in_pc, 1'b0));
         end
         prev_stall[d] = ov && !out_ready;
         prev_o[d]     = o;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_dut(0, obs_a, a_out_valid, a_in_ready);
         mon_dut(1, obs_b, b_out_valid, b_in_ready);
      end
   end

   task automatic issue(input logic [31:0] w, input logic [63:0] pc);
      in_valid = 1'b1;
      in_insn  = w;
      in_pc    = pc;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic start_mon();
      @(posedge clk);
      qclear();
      mon_en = 1'b1;
      #1;
   endtask

   logic [4:0] ops [16] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000,
                            5'b01000, 5'b00100, 5'b01100, 5'b00011, 5'b11100, 5'b00110,
                            5'b01110, 5'b01011, 5'b10100, 5'b11111};
   logic [31:0] stream [4] = '{32'h00100093, 32'h00208113, 32'h4030D193, 32'h00C0A203};

   function automatic logic [31:0] rand_insn();
      logic [31:0] w;
      w      = $urandom;
      w[6:2] = ops[$urandom_range(15, 0)];
      if ($urandom_range(7, 0) != 0) w[1:0] = 2'b11;
      if (w[6:2] == 5'b01100 && $urandom_range(3, 0) != 0)
         w[31:25] = $urandom_range(1, 0) ? 7'h20 : 7'h00;
      return w;
   endfunction

   initial begin
      int idx;
      int cyc;
      logic acc;
      rst = 1'b1;
      #22;
      chk("rst_a_out_valid", 256'(a_out_valid), 256'(0));
      chk("rst_a_in_ready", 256'(a_in_ready), 256'(0));
      chk("rst_b_in_ready", 256'(b_in_ready), 256'(0));
      chk("rst_a_data", 256'(obs_a), 256'(0));
      chk("rst_b_data", 256'(obs_b), 256'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("pre_edge_a_in_ready", 256'(a_in_ready), 256'(0));
      chk("pre_edge_b_in_ready", 256'(b_in_ready), 256'(0));
      start_mon();
      chk("post_edge_a_in_ready", 256'(a_in_ready), 256'(1));
      chk("post_edge_b_in_ready", 256'(b_in_ready), 256'(1));

      out_ready = 1'b1;
      issue(32'h00500093, 64'h100);
      chk("addi_valid", 256'(a_out_valid), 256'(1));
      chk("addi_opcode", 256'(a_opcode), 256'(5'b00100));
      chk("addi_rd", 256'(a_rd), 256'(1));
      chk("addi_rs1", 256'(a_rs1), 256'(0));
      chk("addi_imm", 256'(a_imm), 256'(5));
      chk("addi_alu", 256'(a_alu_op), 256'(0));
      chk("addi_flags", 256'({a_rd_we, a_rs1_used, a_rs2_used, a_illegal}), 256'(4'b1100));
      chk("addi_b_imm", 256'(b_imm), 256'(5));
      issue(32'h4030D093, 64'h104);
      chk("srai_alu_a", 256'(a_alu_op), 256'(4'b1101));
      chk("srai_alu_b", 256'(b_alu_op), 256'(4'b1101));
      chk("srai_imm", 256'(a_imm), 256'(12'h403));
      issue(32'hFE000EE3, 64'h108);
      chk("beq_imm_a", 256'(a_imm), 256'(64'hFFFF_FFFF_FFFF_FFFC));
      chk("beq_imm_b", 256'(b_imm), 256'(32'hFFFF_FFFC));
      chk("beq_rs2_used", 256'(a_rs2_used), 256'(1));
      chk("beq_rd_we", 256'(a_rd_we), 256'(0));
      issue(32'h00000010, 64'h10C);
      chk("low2_illegal", 256'(a_illegal), 256'(1));
      chk("low2_rd_we", 256'(a_rd_we), 256'(0));
      issue(32'h0000202F, 64'h110);
      chk("amo_illegal", 256'(a_illegal), 256'(1));
      issue(32'h002080BB, 64'h114);
      chk("addw_legal_rv64", 256'(a_illegal), 256'(0));
      chk("addw_illegal_rv32", 256'(b_illegal), 256'(1));
      chk("addw_rd_we_rv32", 256'(b_rd_we), 256'(0));
      @(posedge clk); #1;

      // four-deep burst into a stalled consumer
      out_ready = 1'b0;
      idx = 0;
      in_valid = 1'b1;
      in_insn = stream[0];
      in_pc = 64'h200;
      for (cyc = 0; cyc < 30 && idx < 4; cyc++) begin
         if (cyc == 3) begin
            chk("stall_accepts", 256'(idx), 256'(2));
            chk("stall_in_ready", 256'(a_in_ready), 256'(0));
            out_ready = 1'b1;
         end
         @(negedge clk);
         acc = a_in_ready;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 4) begin
               in_insn = stream[idx];
               in_pc   = 64'h200 + 64'(4 * idx);
            end
         end
      end
      in_valid = 1'b0;
      chk("burst_done", 256'(idx), 256'(4));
      repeat (4) @(posedge clk);
      #1;

      // flush with pipe and skid full and an input offered
      out_ready = 1'b0;
      issue(32'h00100093, 64'h300);
      issue(32'h00200113, 64'h304);
      in_valid = 1'b1;
      in_insn  = 32'h00300193;
      flush    = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 256'(a_out_valid), 256'(0));
      chk("flush_in_ready", 256'(a_in_ready), 256'(1));
      out_ready = 1'b1;
      issue(32'h00400213, 64'h308);
      chk("post_flush_rd", 256'(a_rd), 256'(4));
      @(posedge clk); #1;
      chk("post_flush_alone", 256'(a_out_valid), 256'(0));

      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            #2;
            mon_en = 1'b0;
            rst = 1'b1;
            #1;
            chk("midrst_a_out_valid", 256'(a_out_valid), 256'(0));
            chk("midrst_b_out_valid", 256'(b_out_valid), 256'(0));
            chk("midrst_a_in_ready", 256'(a_in_ready), 256'(0));
            chk("midrst_b_in_ready", 256'(b_in_ready), 256'(0));
            chk("midrst_a_data", 256'(obs_a), 256'(0));
            @(negedge clk);
            rst = 1'b0;
            start_mon();
         end
         in_valid  = ($urandom_range(3, 0) != 0);
         in_insn   = rand_insn();
         in_pc     = {$urandom, $urandom};
         out_ready = ($urandom_range(2, 0) != 0);
         flush     = ($urandom_range(39, 0) == 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("drain_a", 256'(q0.size()), 256'(0));
      chk("drain_b", 256'(q1.size()), 256'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
